// File: rtl/data_router_pkt.sv
// data_router_pkt: routes framed RX FIFO packets to PC_TX (loopback/status) or the SLM config write port.
// Define DATA_ROUTER_PKT_ACK_EN to append an ack word to PC_TX after every packet.
module data_router_pkt #(
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int CFG_ADDR_WIDTH  = 6,
  parameter int FIFO_RD_LATENCY = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_rx_fifo_empty,
  output logic                      o_rx_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     i_rx_fifo_data,
  input  logic                      i_tx_busy,
  output logic                      o_tx_start,
  output logic [DATA_WIDTH-1:0]     o_tx_data,
  output logic                      o_cfg_wr_en,
  output logic [CFG_ADDR_WIDTH-1:0] o_cfg_addr,
  output logic [DATA_WIDTH-1:0]     o_cfg_data,
  input  logic                      i_cfg_ready,
  output logic                      o_pkt_done,
  output logic [7:0]                o_err_count
);
  typedef enum logic [2:0] {IDLE, HDR_WAIT, FETCH, DATA_WAIT, ISSUE, STATUS_TX, ACK_TX, DONE} state_t;
`ifdef DATA_ROUTER_PKT_ACK_EN
  localparam state_t END_ST = ACK_TX;
`else
  localparam state_t END_ST = DONE;
`endif
  localparam logic [1:0] LAT = 2'(FIFO_RD_LATENCY);
  state_t state_q, state_d;
  logic [1:0] lat_q, lat_d, cmd_q, cmd_d;
  logic [CFG_ADDR_WIDTH-1:0] ptr_q, ptr_d, cfg_addr_q, cfg_addr_d;
  logic [LEN_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, tx_data_q, tx_data_d, cfg_data_q, cfg_data_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0] err_q, err_d;
  logic rd_en_q, rd_en_d, tx_start_q, tx_start_d, cfg_wr_en_q, cfg_wr_en_d, pkt_done_q, pkt_done_d;
  logic lat_done, tx_ok, word_ok;
  logic [1:0] hdr_cmd;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [DATA_WIDTH-1:0] status_word;
  assign lat_done    = lat_q == LAT;
  assign hdr_cmd     = i_rx_fifo_data[1:0];
  assign hdr_len     = i_rx_fifo_data[LEN_WIDTH+15:16];
  assign status_word = DATA_WIDTH'({pkt_cnt_q, err_q, 8'h00});
  // busy is ignored the cycle after a start so the serialiser has time to raise it
  assign tx_ok   = !i_tx_busy && !tx_start_q;
  assign word_ok = cmd_q == 2'd0 ? tx_ok : cmd_q == 2'd1 ? cfg_wr_en_q && i_cfg_ready : 1'b1;
`ifdef DATA_ROUTER_PKT_ACK_EN
  logic [LEN_WIDTH-1:0] n_q, n_d;
  logic [DATA_WIDTH-1:0] ack_word;
  assign n_d      = state_q == HDR_WAIT && lat_done ? hdr_len : n_q;
  assign ack_word = DATA_WIDTH'({8'hA5, 6'h00, cmd_q, 16'(n_q)});
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) n_q <= '0;
    else n_q <= n_d;
`endif
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q + 2'd1;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    left_d      = left_q;
    word_d      = word_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_d       = err_q;
    rd_en_d     = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    cfg_wr_en_d = cfg_wr_en_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    pkt_done_d  = 1'b0;
    case (state_q)
      IDLE: if (!i_rx_fifo_empty) begin
        rd_en_d = 1'b1;
        lat_d   = '0;
        state_d = HDR_WAIT;
      end
      HDR_WAIT: if (lat_done) begin
        cmd_d   = hdr_cmd;
        ptr_d   = i_rx_fifo_data[CFG_ADDR_WIDTH+1:2];
        left_d  = hdr_len;
        state_d = hdr_len != '0 ? FETCH : hdr_cmd == 2'd2 ? STATUS_TX : END_ST;
      end
      FETCH: if (left_q != '0 && !i_rx_fifo_empty) begin
        rd_en_d = 1'b1;
        lat_d   = '0;
        state_d = DATA_WAIT;
      end
      DATA_WAIT: if (lat_done) begin
        word_d  = i_rx_fifo_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_q == 2'd0 && tx_ok) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q;
        end
        if (cmd_q == 2'd1 && !cfg_wr_en_q) begin
          cfg_wr_en_d = 1'b1;
          cfg_addr_d  = ptr_q;
          cfg_data_d  = word_q;
        end
        if (cmd_q == 2'd1 && cfg_wr_en_q && i_cfg_ready) begin
          cfg_wr_en_d = 1'b0;
          ptr_d       = ptr_q + CFG_ADDR_WIDTH'(1);
        end
        if (word_ok) begin
          left_d  = left_q - LEN_WIDTH'(1);
          state_d = left_q != LEN_WIDTH'(1) ? FETCH : cmd_q == 2'd2 ? STATUS_TX : END_ST;
        end
      end
      STATUS_TX: if (tx_ok) begin
        tx_start_d = 1'b1;
        tx_data_d  = status_word;
        state_d    = END_ST;
      end
`ifdef DATA_ROUTER_PKT_ACK_EN
      ACK_TX: if (tx_ok) begin
        tx_start_d = 1'b1;
        tx_data_d  = ack_word;
        state_d    = DONE;
      end
`endif
      DONE: begin
        pkt_done_d = 1'b1;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
        err_d      = cmd_q == 2'd3 && err_q != 8'hFF ? err_q + 8'd1 : err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cmd_q       <= '0;
      ptr_q       <= '0;
      left_q      <= '0;
      word_q      <= '0;
      pkt_cnt_q   <= '0;
      err_q       <= '0;
      rd_en_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      cfg_wr_en_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      word_q      <= word_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      cfg_wr_en_q <= cfg_wr_en_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      pkt_done_q  <= pkt_done_d;
    end
  assign o_rx_fifo_rd_en = rd_en_q;
  assign o_tx_start      = tx_start_q;
  assign o_tx_data       = tx_data_q;
  assign o_cfg_wr_en     = cfg_wr_en_q;
  assign o_cfg_addr      = cfg_addr_q;
  assign o_cfg_data      = cfg_data_q;
  assign o_pkt_done      = pkt_done_q;
  assign o_err_count     = err_q;
endmodule

// File: tb/tb_data_router_pkt.sv
// tb_data_router_pkt: directed bench for data_router_pkt with FIFO, PC_TX and config sink models.
module tb_data_router_pkt;
  localparam int LAT = 3;
  logic clk = 1'b0, rst_n = 1'b0, empty = 1'b1;
  logic [31:0] fifo_data, tx_data, cfg_data;
  logic rd_en, tx_busy, tx_start, cfg_wr_en, cfg_ready, pkt_done, pend = 1'b0;
  logic [5:0] cfg_addr;
  logic [7:0] err_count;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0, pop_v;
  logic [31:0] fq[$], txq[$], cfg_dq[$];
  logic [5:0] cfg_aq[$];
  int bcnt = 0, wcnt = 0, done_cnt = 0, rd_cnt = 0, rd_empty = 0, busy_viol = 0, hold_err = 0;
  int n_checks = 0, n_fail = 0, r0, c0;
  always #5 clk = ~clk;
  assign fifo_data = p2;
  assign tx_busy   = bcnt > 0;
  assign cfg_ready = cfg_wr_en && wcnt >= 2;
  data_router_pkt #(.DATA_WIDTH(32), .LEN_WIDTH(8), .CFG_ADDR_WIDTH(6), .FIFO_RD_LATENCY(LAT)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx_fifo_empty(empty), .o_rx_fifo_rd_en(rd_en),
    .i_rx_fifo_data(fifo_data), .i_tx_busy(tx_busy), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_cfg_wr_en(cfg_wr_en), .o_cfg_addr(cfg_addr), .o_cfg_data(cfg_data), .i_cfg_ready(cfg_ready),
    .o_pkt_done(pkt_done), .o_err_count(err_count));
  // FIFO with LAT-cycle read data, TX serialiser busy for 10 cycles per start, config sink ready after 2 cycles
  always @(posedge clk) begin
    pop_v = '0;
    if (!rst_n) begin
      p0 <= '0; p1 <= '0; p2 <= '0; bcnt <= 0; wcnt <= 0; pend <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        if (fq.size() == 0) rd_empty++;
        else pop_v = fq.pop_front();
        empty <= fq.size() == 0;
      end
      p0 <= pop_v; p1 <= p0; p2 <= p1;
      if (tx_start) begin
        txq.push_back(tx_data);
        if (tx_busy) busy_viol++;
        bcnt <= 10;
      end else if (bcnt > 0) bcnt <= bcnt - 1;
      if (cfg_wr_en && cfg_ready) begin
        cfg_aq.push_back(cfg_addr);
        cfg_dq.push_back(cfg_data);
        wcnt <= 0;
      end else if (cfg_wr_en) wcnt <= wcnt + 1;
      if (pend && !cfg_wr_en) hold_err++;
      pend <= cfg_wr_en && !cfg_ready;
      if (pkt_done) done_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    empty = 1'b0;
  endtask
  task automatic wait_pkts(input int target);
    for (int i = 0; i < 2000 && done_cnt < target; i++) @(negedge clk);
    chk("pkt_done_count", done_cnt, target);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {rd_en, tx_start, cfg_wr_en, pkt_done}, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    push(32'h0003_0000); push(32'h11); push(32'h22); push(32'h33);
    wait_pkts(1);
    chk("lb_tx_count", txq.size(), 3);
    chk("lb_w0", txq[0], 32'h11);
    chk("lb_w1", txq[1], 32'h22);
    chk("lb_w2", txq[2], 32'h33);
    chk("lb_busy_viol", busy_viol, 0);
    chk("lb_rd_cnt", rd_cnt, 4);
    chk("lb_no_cfg", cfg_aq.size(), 0);
    push(32'h0003_00F9); push(32'hC0DE_0000); push(32'hC0DE_0001); push(32'hC0DE_0002);
    wait_pkts(2);
    chk("cfg_count", cfg_aq.size(), 3);
    chk("cfg_a0", cfg_aq[0], 62);
    chk("cfg_a1", cfg_aq[1], 63);
    chk("cfg_a2", cfg_aq[2], 0);
    chk("cfg_d0", cfg_dq[0], 32'hC0DE_0000);
    chk("cfg_d1", cfg_dq[1], 32'hC0DE_0001);
    chk("cfg_d2", cfg_dq[2], 32'hC0DE_0002);
    chk("cfg_hold", hold_err, 0);
    chk("cfg_no_tx", txq.size(), 3);
    do_reset();
    txq.delete();
    push(32'h0002_0003); push(32'h1); push(32'h2);
    push(32'h0002_0003); push(32'h3); push(32'h4);
    push(32'h0000_0002);
    wait_pkts(5);
    chk("st_err_count", err_count, 2);
    chk("st_tx_count", txq.size(), 1);
    chk("st_word", txq[0], 32'h0002_0200);
    txq.delete();
    r0 = rd_cnt;
    push(32'h0002_0000); push(32'h77);
    repeat (20) @(negedge clk);
    chk("starve_rd_mid", rd_cnt - r0, 2);
    chk("starve_tx_mid", txq.size(), 1);
    chk("starve_no_done", done_cnt, 5);
    repeat (30) @(negedge clk);
    push(32'h88);
    wait_pkts(6);
    chk("starve_rd_end", rd_cnt - r0, 3);
    chk("starve_rd_empty", rd_empty, 0);
    chk("starve_w0", txq[0], 32'h77);
    chk("starve_w1", txq[1], 32'h88);
    txq.delete();
    c0 = cfg_aq.size();
    push(32'h0004_0001); push(32'h5A); push(32'h5B);
    repeat (40) @(negedge clk);
    chk("mid_cfg_writes", cfg_aq.size() - c0, 2);
    chk("mid_cfg_addr", cfg_addr, 1);
    chk("mid_cfg_data", cfg_data, 32'h5B);
    chk("mid_err", err_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cfg_addr", cfg_addr, 0);
    chk("async_cfg_data", cfg_data, 0);
    chk("async_err", err_count, 0);
    chk("async_tx_data", tx_data, 0);
    fq.delete();
    empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(32'h0001_0000); push(32'h99); push(32'h0000_0002);
    wait_pkts(8);
    chk("post_tx_count", txq.size(), 2);
    chk("post_w0", txq[0], 32'h99);
    chk("post_status", txq[1], 32'h0001_0000);
    chk("post_busy_viol", busy_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
